// File: rtl/td4_pkg.sv
// Shared TD4 definitions: mnemonic IDs, opcode table, instruction encoding and loader FSM states.
// The decoder side imports the same table, so the two can never drift apart.
package td4_pkg;

    localparam logic [3:0] MN_ADDA_IM = 4'd0;
    localparam logic [3:0] MN_MOVA_B  = 4'd1;
    localparam logic [3:0] MN_MOVA_IM = 4'd2;
    localparam logic [3:0] MN_MOVB_A  = 4'd3;
    localparam logic [3:0] MN_ADDB_IM = 4'd4;
    localparam logic [3:0] MN_MOVB_IM = 4'd5;
    localparam logic [3:0] MN_HLT     = 4'd6;
    localparam logic [3:0] MN_JMP     = 4'd7;
    localparam logic [3:0] MN_JNZ     = 4'd8;

    localparam logic [7:0] HLT_BYTE = 8'h60;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    function automatic logic mn_illegal(input logic [3:0] mn);
        return mn > MN_JNZ;
    endfunction

    function automatic logic [3:0] opc(input logic [3:0] mn);
        logic [3:0] o;
        case (mn)
            MN_ADDA_IM: o = 4'b0000;
            MN_MOVA_B:  o = 4'b0001;
            MN_MOVA_IM: o = 4'b0011;
            MN_MOVB_A:  o = 4'b0100;
            MN_ADDB_IM: o = 4'b0101;
            MN_MOVB_IM: o = 4'b0111;
            MN_JMP:     o = 4'b1011;
            MN_JNZ:     o = 4'b1111;
            default:    o = 4'b0110;
        endcase
        return o;
    endfunction

    // Register-to-register moves and HLT carry no operand, so their nibble is zeroed.
    function automatic logic [7:0] enc(input logic [3:0] mn, input logic [3:0] imm);
        logic [3:0] i;
        i = (mn == MN_MOVA_B || mn == MN_MOVB_A || mn == MN_HLT) ? 4'h0 : imm;
        return {opc(mn), i};
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Program store: DEPTH x 8, one synchronous write port and one registered read port.
module prog_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/prog_loader.sv
// Encodes a mnemonic stream into instruction bytes, stores them in prog_ram and serves them
// to the fetch path once the program is complete.
module prog_loader
    import td4_pkg::*;
#(
    parameter int         DEPTH    = 16,
    parameter int         ADDR_W   = 4,
    parameter logic [7:0] HLT_FILL = HLT_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mn,
    input  logic [3:0]        in_imm,
    input  logic              in_last,
    output logic              loading,
    output logic              prog_ok,
    output logic              err,
    output logic              ovf,
    output logic [ADDR_W:0]   count,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [7:0]        fetch_data,
    output logic [1:0]        dbg_state
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    state_t state_q, state_n;
    logic   accept, illegal, wr_en, fetch_ok_q;
    logic [7:0] ram_rdata;

    // Handshake: a beat transfers on a rising edge where in_valid & in_ready; in_ready is a
    // flop that is high exactly while in LOAD, and a same-cycle start suppresses the transfer.
    assign accept  = in_valid && in_ready && !start;
    assign illegal = mn_illegal(in_mn);
    assign wr_en   = accept && !illegal;

    always_comb begin
        state_n = state_q;
        if (start) begin
            state_n = ST_LOAD;
        end else if (state_q == ST_LOAD && accept) begin
            if (illegal) begin
                state_n = ST_ERR;
            end else if (in_last || count == LAST_IDX) begin
                state_n = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_ready   <= 1'b0;
            count      <= '0;
            err        <= 1'b0;
            ovf        <= 1'b0;
            fetch_ok_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            in_ready   <= (state_n == ST_LOAD);
            fetch_ok_q <= (state_q == ST_DONE) && ({1'b0, fetch_addr} < count);
            if (start) begin
                count <= '0;
                err   <= 1'b0;
                ovf   <= 1'b0;
            end else if (accept) begin
                if (illegal) begin
                    err <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                    if (!in_last && count == LAST_IDX) begin
                        ovf <= 1'b1;
                    end
                end
            end
        end
    end

    prog_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (count[ADDR_W-1:0]),
        .wdata (enc(in_mn, in_imm)),
        .raddr (fetch_addr),
        .rdata (ram_rdata)
    );

    // Both terms are registered, so fetch_data changes only on the clock edge.
    assign fetch_data = fetch_ok_q ? ram_rdata : HLT_FILL;
    assign loading    = (state_q == ST_LOAD);
    assign prog_ok    = (state_q == ST_DONE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table-driven program loads plus hand-written corner sequences.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, in_ready, in_last;
    logic [3:0] in_mn, in_imm, fetch_addr;
    logic       loading, prog_ok, err, ovf;
    logic [4:0] count;
    logic [7:0] fetch_data;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [3:0] mn;
        logic [3:0] imm;
        logic       last;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[10];

    prog_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mn      (in_mn),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .loading    (loading),
        .prog_ok    (prog_ok),
        .err        (err),
        .ovf        (ovf),
        .count      (count),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [3:0] mn, input logic [3:0] imm, input logic last);
        int guard = 0;
        in_valid = 1'b1;
        in_mn    = mn;
        in_imm   = imm;
        in_last  = last;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready 0 expected 1");
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic fetch_check(input string name, input logic [3:0] addr, input logic [7:0] exp);
        fetch_addr = addr;
        step();
        check(name, fetch_data, exp);
    endtask

    task automatic drain_and_check(input string name);
        int n;
        n = exp_q.size();
        check({name, "_count"}, count, n);
        check({name, "_prog_ok"}, prog_ok, 1);
        for (int a = 0; a < n; a++) begin
            fetch_check({name, "_fetch"}, a[3:0], exp_q.pop_front());
        end
        if (n < 16) fetch_check({name, "_past_end"}, n[3:0], 8'h60);
    endtask

    initial begin
        vecs[0] = '{4'd2, 4'h5, 1'b0, 8'h35};
        vecs[1] = '{4'd0, 4'h3, 1'b0, 8'h03};
        vecs[2] = '{4'd7, 4'h1, 1'b1, 8'hB1};
        vecs[3] = '{4'd1, 4'hF, 1'b0, 8'h10};
        vecs[4] = '{4'd6, 4'hA, 1'b1, 8'h60};
        vecs[5] = '{4'd3, 4'h7, 1'b0, 8'h40};
        vecs[6] = '{4'd4, 4'h9, 1'b0, 8'h59};
        vecs[7] = '{4'd5, 4'h2, 1'b0, 8'h72};
        vecs[8] = '{4'd8, 4'hC, 1'b0, 8'hFC};
        vecs[9] = '{4'd0, 4'hE, 1'b1, 8'h0E};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_mn = '0; in_imm = '0;
        in_last = 1'b0; fetch_addr = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        check("rst_in_ready", in_ready, 0);
        check("rst_loading", loading, 0);
        check("rst_prog_ok", prog_ok, 0);
        check("rst_err", err, 0);
        check("rst_ovf", ovf, 0);
        check("rst_count", count, 0);
        check("rst_fetch", fetch_data, 8'h60);
        check("rst_state", dbg_state, 0);

        // Table-driven programs: each in_last closes one program, which is then read back.
        pulse_start();
        check("start_loading", loading, 1);
        check("start_in_ready", in_ready, 1);
        for (int v = 0; v < 10; v++) begin
            send_beat(vecs[v].mn, vecs[v].imm, vecs[v].last);
            exp_q.push_back(vecs[v].exp_byte);
            if (vecs[v].last) begin
                check("done_in_ready", in_ready, 0);
                drain_and_check("tbl");
                if (v < 9) pulse_start();
            end
        end

        // Illegal mnemonic: consumed, not stored, lands in ERR.
        pulse_start();
        send_beat(4'd0, 4'h1, 1'b0);
        send_beat(4'd12, 4'h3, 1'b0);
        check("ill_err", err, 1);
        check("ill_state", dbg_state, 3);
        check("ill_count", count, 1);
        check("ill_in_ready", in_ready, 0);
        check("ill_prog_ok", prog_ok, 0);
        fetch_check("ill_fetch0", 4'h0, 8'h60);

        // Overflow: 16 beats without in_last.
        pulse_start();
        check("start_clr_err", err, 0);
        for (int i = 0; i < 16; i++) begin
            send_beat(4'd4, i[3:0], 1'b0);
        end
        check("ovf_flag", ovf, 1);
        check("ovf_prog_ok", prog_ok, 1);
        check("ovf_count", count, 16);
        fetch_check("ovf_fetchF", 4'hF, 8'h5F);
        fetch_check("ovf_fetch0", 4'h0, 8'h50);
        fetch_check("ovf_fetch7", 4'h7, 8'h57);

        // in_valid gaps: an illegal ID parked on the bus while invalid must be ignored.
        pulse_start();
        check("start_clr_ovf", ovf, 0);
        in_valid = 1'b1; in_mn = 4'd2; in_imm = 4'h1; in_last = 1'b0;
        step();
        in_valid = 1'b0; in_mn = 4'd12; in_imm = 4'h9;
        step();
        step();
        check("gap_count", count, 1);
        in_valid = 1'b1; in_mn = 4'd2; in_imm = 4'h2;
        step();
        in_imm = 4'h3; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check("gap_err", err, 0);
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h33);
        drain_and_check("gap");

        // start from DONE, start beating a same-cycle beat, then reset mid-LOAD.
        pulse_start();
        check("restart_prog_ok", prog_ok, 0);
        check("restart_count", count, 0);
        check("restart_loading", loading, 1);
        send_beat(4'd2, 4'h4, 1'b0);
        send_beat(4'd2, 4'h5, 1'b0);
        check("pre_prio_count", count, 2);
        start = 1'b1; in_valid = 1'b1; in_mn = 4'd0; in_imm = 4'h1;
        step();
        start = 1'b0; in_valid = 1'b0;
        check("prio_count", count, 0);
        send_beat(4'd2, 4'h6, 1'b0);
        send_beat(4'd2, 4'h7, 1'b0);
        check("mid_count", count, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_count", count, 0);
        check("mrst_prog_ok", prog_ok, 0);
        check("mrst_in_ready", in_ready, 0);
        check("mrst_loading", loading, 0);
        check("mrst_fetch", fetch_data, 8'h60);
        fetch_check("mrst_fetch0", 4'h0, 8'h60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
